// File: rtl/decode_sched_if.sv
// Decode/scheduler control bundle: IF/ID instruction, hazard and memory status in; pipeline enables out.
// stall_cycles is present only when STALL_CNT_EN is defined.
interface decode_sched_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        freeze;
  logic [2:0]  imm_sel;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;

  modport master (
    output instr, instr_valid, idex_memread, idex_rd, branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, freeze, imm_sel, stall_cycles
  );
  modport slave (
    input  instr, instr_valid, idex_memread, idex_rd, branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, freeze, imm_sel, stall_cycles
  );
`else
  modport master (
    output instr, instr_valid, idex_memread, idex_rd, branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, freeze, imm_sel
  );
  modport slave (
    input  instr, instr_valid, idex_memread, idex_rd, branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, freeze, imm_sel
  );
`endif
endinterface

// File: rtl/decode_sched.sv
// Decode-stage scheduler: immediate-format decode, load-use stall, branch squash window and memory freeze.
// Optional STALL_CNT_EN adds a saturating 16-bit count of cycles with the PC held.
module decode_sched #(
  parameter int unsigned FLUSH_LEN = 2
) (
  input logic          clk,
  input logic          reset,
  decode_sched_if.slave bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN - 1);

  logic [0:0]  state, state_nxt;
  logic [2:0]  flush_cnt, cnt_nxt;
  logic [10:0] op;
  logic [2:0]  dec;
  logic        is_stur, use1, use2, hazard, frozen;
  logic [4:0]  src2;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, freeze;
  logic        unused_bits;

  assign op          = bus.instr[31:21];
  assign unused_bits = ^bus.instr[15:10];

  always_comb begin
    dec = 3'd0;
    casez (op)
      11'b11111000010, 11'b11111000000: dec = 3'd1;
      11'b10110100???:                  dec = 3'd2;
      11'b1001000100?, 11'b1001001000?,
      11'b1011001000?, 11'b1101000100?: dec = 3'd3;
      11'b110100101??:                  dec = 3'd4;
      default:                          dec = 3'd0;
    endcase
  end

  // CBZ/MOVZ have no Rn; STUR/CBZ read Rt from [4:0], R-format reads Rm from [20:16].
  assign is_stur = (op == 11'b11111000000);
  assign use1    = (dec != 3'd2) && (dec != 3'd4);
  assign use2    = is_stur || (dec == 3'd2) || (dec == 3'd0);
  assign src2    = (dec == 3'd0) ? bus.instr[20:16] : bus.instr[4:0];

  assign hazard = (state == RUN) && bus.instr_valid && bus.idex_memread &&
                  (bus.idex_rd != 5'd31) &&
                  ((use1 && (bus.idex_rd == bus.instr[9:5])) ||
                   (use2 && (bus.idex_rd == src2)));

  assign frozen = bus.mem_req && !bus.mem_ready;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    state_nxt   = state;
    cnt_nxt     = flush_cnt;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (frozen) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      freeze  = 1'b1;
    end else if (bus.branch_taken) begin
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = FLUSH;
      cnt_nxt     = FLUSH_INIT;
    end else if (state == FLUSH) begin
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (flush_cnt == 3'd0) state_nxt = RUN;
      else                   cnt_nxt   = flush_cnt - 3'd1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= cnt_nxt;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.freeze      = freeze;
  assign bus.imm_sel     = (reset || !bus.instr_valid || (state == FLUSH)) ? 3'd0 : dec;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cycles <= '0;
    else if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
  end

  assign bus.stall_cycles = stall_cycles;
`endif

endmodule

// File: tb/tb_decode_sched.sv
// Self-checking bench for decode_sched against a cycle-level reference model.
// Also covers the stall counter when built with STALL_CNT_EN.
module tb_decode_sched;
  localparam int unsigned FL = 2;

  logic clk;
  logic reset;
  decode_sched_if bus ();

  decode_sched #(.FLUSH_LEN(FL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int rem = 0;       // squash cycles still owed after the current one
  int stall_m = 0;

  logic [7:0] obs;
  assign obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.freeze, bus.imm_sel};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] ref_imm(input logic [31:0] ins);
    int op = int'(ins[31:21]);
    if (op == 'h7C2 || op == 'h7C0) return 3'd1;
    if ((op >> 3) == 'hB4) return 3'd2;
    if ((op >> 1) == 'h244 || (op >> 1) == 'h248 || (op >> 1) == 'h2C8 || (op >> 1) == 'h344) return 3'd3;
    if ((op >> 2) == 'h1A5) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic ref_hazard();
    logic [2:0] f = ref_imm(bus.instr);
    int rd = int'(bus.idex_rd);
    int rn = int'(bus.instr[9:5]);
    int rt = int'(bus.instr[4:0]);
    int rm = int'(bus.instr[20:16]);
    logic hit = 1'b0;
    if (rem != 0 || !bus.instr_valid || !bus.idex_memread || rd == 31) return 1'b0;
    if (f != 3'd2 && f != 3'd4 && rd == rn) hit = 1'b1;
    if ((bus.instr[31:21] == 11'h7C0 || f == 3'd2) && rd == rt) hit = 1'b1;
    if (f == 3'd0 && rd == rm) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [7:0] model_out();
    logic [2:0] imm = (bus.instr_valid && rem == 0) ? ref_imm(bus.instr) : 3'd0;
    if (reset) return 8'b0011_0000;
    if (bus.mem_req && !bus.mem_ready) return {5'b00001, imm};
    if (bus.branch_taken || rem > 0) return {5'b10110, imm};
    if (ref_hazard()) return {5'b00010, imm};
    return {5'b11000, imm};
  endfunction

  function automatic void model_update();
    logic [7:0] o = model_out();
    if (reset) begin
      rem = 0;
      stall_m = 0;
      return;
    end
    if (!o[7] && stall_m < 65535) stall_m++;
    if (bus.mem_req && !bus.mem_ready) return;
    if (bus.branch_taken) rem = FL;
    else if (rem > 0) rem--;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.instr        = 32'h0;
    bus.instr_valid  = 1'b0;
    bus.idex_memread = 1'b0;
    bus.idex_rd      = 5'd0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    vectors++;
    if (obs !== 8'b0011_0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0011_0000);
    end
    tick();
`ifdef STALL_CNT_EN
    vectors++;
    if (bus.stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cycles);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected %b", obs, 8'b1100_0000);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    bus.instr        = 32'h8B030041;
    bus.instr_valid  = 1'b1;
    bus.idex_memread = 1'b1;
    bus.idex_rd      = 5'd2;
    @(negedge clk);
    vectors++;
    if (obs !== 8'b0001_0000) begin
      miscompares++;
      $display("FAIL load_use_stall: got %b expected %b", obs, 8'b0001_0000);
    end
    tick();
    bus.idex_memread = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL load_use_resume: got %b expected %b", obs, 8'b1100_0000);
    end
    tick();
    bus.idex_memread = 1'b1;
    bus.idex_rd      = 5'd31;
    @(negedge clk);
    vectors++;
    if (obs !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL load_use_xzr: got %b expected %b", obs, 8'b1100_0000);
    end
    tick();
    idle();
  endtask

  task automatic test_branch(input bit second);
    int n = 0;
    int i;
    idle();
    for (i = 0; i < 12; i++) begin
      bus.branch_taken = (i == 0) || (second && i == 2);
      @(negedge clk);
      vectors++;
      if (obs !== model_out()) begin
        miscompares++;
        $display("FAIL branch_cycle%0d: got %b expected %b", i, obs, model_out());
      end
      if (!bus.ifid_flush) break;
      n++;
      tick();
    end
    vectors++;
    if (n != (second ? 5 : 3) || bus.ifid_en !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_window: got %0d flush cycles ifid_en=%b expected %0d and 1",
               n, bus.ifid_en, second ? 5 : 3);
    end
    tick();
  endtask

  task automatic test_freeze();
    int n = 0;
    idle();
    bus.branch_taken = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b1;
    bus.mem_ready    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.branch_taken = (i == 1);
      @(negedge clk);
      vectors++;
      if (obs !== 8'b0000_1000) begin
        miscompares++;
        $display("FAIL freeze_cycle%0d: got %b expected %b", i, obs, 8'b0000_1000);
      end
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.ifid_flush) break;
      n++;
      tick();
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL freeze_resume: got %0d flush cycles expected 2", n);
    end
    tick();
  endtask

  task automatic test_imm_sel();
    logic [31:0] ins [5] = '{32'hF84083E1, 32'hB4000041, 32'h91000421, 32'hD2800021, 32'h8B030041};
    logic [2:0]  exp [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.instr       = ins[i];
      bus.instr_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.imm_sel !== exp[i]) begin
        miscompares++;
        $display("FAIL imm_sel_%h: got %0d expected %0d", ins[i], bus.imm_sel, exp[i]);
      end
      tick();
      bus.instr_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.imm_sel !== 3'd0) begin
        miscompares++;
        $display("FAIL imm_sel_invalid_%h: got %0d expected 0", ins[i], bus.imm_sel);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    bus.instr        = 32'h91000421;
    bus.instr_valid  = 1'b1;
    bus.branch_taken = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    rem = 0;
    stall_m = 0;
    #1;
    vectors++;
    if (obs !== 8'b0011_0000) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b expected %b", obs, 8'b0011_0000);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== 8'b1100_0011) begin
      miscompares++;
      $display("FAIL async_reset_run: got %b expected %b", obs, 8'b1100_0011);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] ops [6] = '{32'hF8400000, 32'hF8000000, 32'hB4000000, 32'h91000000,
                             32'hD2800000, 32'h8B000000};
    for (int i = 0; i < 600; i++) begin
      bus.instr        = ($urandom_range(0, 3) == 0) ? $urandom()
                       : (ops[$urandom_range(0, 5)] | ($urandom() & 32'h001F03FF));
      bus.instr_valid  = ($urandom_range(0, 4) != 0);
      bus.idex_memread = $urandom_range(0, 1) == 1;
      bus.idex_rd      = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.mem_req      = ($urandom_range(0, 3) == 0);
      bus.mem_ready    = $urandom_range(0, 1) == 1;
      reset            = ($urandom_range(0, 99) == 0);
      if (reset) begin
        rem = 0;
        stall_m = 0;
      end
      @(negedge clk);
      vectors++;
      if (obs !== model_out()) begin
        miscompares++;
        $display("FAIL random_%0d: got %b expected %b", i, obs, model_out());
      end
      tick();
    end
    reset = 1'b0;
    idle();
`ifdef STALL_CNT_EN
    vectors++;
    if (int'(bus.stall_cycles) != stall_m) begin
      miscompares++;
      $display("FAIL random_stall_cnt: got %0d expected %0d", bus.stall_cycles, stall_m);
    end
`endif
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_saturate();
    idle();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 65540; i++) tick();
    @(negedge clk);
    vectors++;
    if (bus.stall_cycles !== 16'hFFFF || stall_m != 65535) begin
      miscompares++;
      $display("FAIL stall_saturate: got %h expected ffff", bus.stall_cycles);
    end
    idle();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch(1'b0);
    test_branch(1'b1);
    test_freeze();
    test_imm_sel();
    test_async_reset();
    test_random();
`ifdef STALL_CNT_EN
    test_stall_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
